// File: rtl/reg_bank_dbuf.sv
// Byte-enabled, double-buffered register bank: the bus writes shadow registers,
// and a commit pulse copies all of them into the active registers that drive q.
module reg_bank_dbuf #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 4,
    parameter int                ADDR_W    = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       write,
    input  logic                       read,
    input  logic [DATA_W/8-1:0]        byteenable,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    input  logic                       commit,
    output logic [NUM_REGS*DATA_W-1:0] q,
    output logic                       pending,
    output logic                       error
);
    localparam int              NUM_LANES   = DATA_W / 8;
    // One extra bit so the range check can never wrap, even when 2**ADDR_W == NUM_REGS.
    localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] r_shadow [NUM_REGS];
    logic [DATA_W-1:0] r_active [NUM_REGS];
    logic [DATA_W-1:0] r_readdata;
    logic              r_readdatavalid;
    logic              r_pending;
    logic              r_error;

    logic              w_in_range;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_wr_mask;
    logic [DATA_W-1:0] w_rd_word;

    assign w_in_range = ({1'b0, address} < LP_NUM_REGS);
    assign w_wr_ok    = write && w_in_range;

    always_comb begin
        w_wr_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_wr_mask[8*i +: 8] = {8{byteenable[i]}};
        end
    end

    // Out-of-range addresses match no register, so the mux naturally yields zero.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (address == ADDR_W'(k)) begin
                w_rd_word = r_shadow[k];
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so the commit copy
    // sees pre-edge shadow values even when a write lands on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the register array is small and visible on q, so every entry is
            // reset explicitly rather than left for software to initialise.
            for (int k = 0; k < NUM_REGS; k++) begin
                r_shadow[k] <= RESET_VAL;
                r_active[k] <= RESET_VAL;
            end
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_pending       <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit) begin
                    r_active[k] <= r_shadow[k];
                end
                if (w_wr_ok && (address == ADDR_W'(k))) begin
                    r_shadow[k] <= (r_shadow[k] & ~w_wr_mask) | (writedata & w_wr_mask);
                end
            end

            r_readdatavalid <= read;
            if (read) begin
                r_readdata <= w_rd_word;
            end

            // A landing write wins over a same-cycle commit: the new data is not yet active.
            if (w_wr_ok) begin
                r_pending <= 1'b1;
            end else if (commit) begin
                r_pending <= 1'b0;
            end

            if ((read || write) && !w_in_range) begin
                r_error <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign q[g*DATA_W +: DATA_W] = r_active[g];
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign pending       = r_pending;
    assign error         = r_error;

endmodule

// File: tb/tb_reg_bank_dbuf.sv
// Directed bench for reg_bank_dbuf (3 registers, 2-bit address, non-zero reset value);
// read responses are checked by a queue-based scoreboard monitor.
module tb_reg_bank_dbuf;
    localparam int          DATA_W   = 32;
    localparam int          NUM_REGS = 3;
    localparam int          ADDR_W   = 2;
    localparam logic [31:0] RV       = 32'hA5A5_0000;

    logic                       clock;
    logic                       reset;
    logic [ADDR_W-1:0]          address;
    logic                       write;
    logic                       read;
    logic [DATA_W/8-1:0]        byteenable;
    logic [DATA_W-1:0]          writedata;
    logic [DATA_W-1:0]          readdata;
    logic                       readdatavalid;
    logic                       commit;
    logic [NUM_REGS*DATA_W-1:0] q;
    logic                       pending;
    logic                       error;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    logic [31:0] exp_q[$];

    reg_bank_dbuf #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .RESET_VAL(RV)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write        (write),
        .read         (read),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .commit       (commit),
        .q            (q),
        .pending      (pending),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle; a read pushes its hand-computed response for the monitor.
    task automatic bus(input logic wr, input logic rd, input logic cm, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp_rd);
        write      = wr;
        read       = rd;
        commit     = cm;
        address    = a;
        byteenable = be;
        writedata  = wd;
        if (rd) exp_q.push_back(exp_rd);
        @(posedge clock);
        #1;
        write  = 1'b0;
        read   = 1'b0;
        commit = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp_rd);
        bus(1'b0, 1'b1, 1'b0, a, 4'h0, 32'h0, exp_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd);
        bus(1'b1, 1'b0, 1'b0, a, be, wd, 32'h0);
    endtask

    task automatic cm();
        bus(1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 32'h0, 32'h0);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (readdatavalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rdv_unexpected", readdatavalid, 1'b0);
                end else begin
                    check("readdata", readdata, exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_before;
        reset = 1'b0;
        write = 1'b0; read = 1'b0; commit = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_q", q, {3{RV}});
        check("rst_pending", pending, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_rdv", readdatavalid, 1'b0);
        check("rst_readdata", readdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset contents readable from every register.
        rd(2'd0, RV);
        rd(2'd1, RV);
        rd(2'd2, RV);
        check("idle_pending", pending, 1'b0);

        // Partial-lane write: lanes 0 and 2 replace bytes of A5A5_0000.
        wr(2'd2, 4'b0101, 32'h1122_3344);
        check("bw_q_unchanged", q, {3{RV}});
        check("bw_pending", pending, 1'b1);
        rd(2'd2, 32'hA522_0044);
        cm();
        check("bw_commit_q", q, {32'hA522_0044, RV, RV});
        check("bw_commit_pending", pending, 1'b0);

        // Zero byteenable: no data change but pending still set; idle commit is invisible.
        wr(2'd0, 4'b0000, 32'hFFFF_FFFF);
        check("be0_pending", pending, 1'b1);
        rd(2'd0, RV);
        cm();
        check("be0_commit_pending", pending, 1'b0);
        cm();
        check("idle_commit_q", q, {32'hA522_0044, RV, RV});

        // Same-cycle write + read + commit to register 1.
        bus(1'b1, 1'b1, 1'b1, 2'd1, 4'hF, 32'hDEAD_BEEF, RV);
        check("wrc_q", q, {32'hA522_0044, RV, RV});
        check("wrc_pending", pending, 1'b1);
        rd(2'd1, 32'hDEAD_BEEF);
        cm();
        check("wrc_commit_q", q, {32'hA522_0044, 32'hDEAD_BEEF, RV});
        check("wrc_commit_pending", pending, 1'b0);

        // Out-of-range address 3: write ignored, read returns zero, error sticks.
        wr(2'd3, 4'hF, 32'hFFFF_FFFF);
        check("oob_wr_error", error, 1'b1);
        check("oob_wr_pending", pending, 1'b0);
        rd(2'd3, 32'h0);
        rd(2'd0, RV);
        rd(2'd1, 32'hDEAD_BEEF);
        rd(2'd2, 32'hA522_0044);
        check("oob_error_sticky", error, 1'b1);

        // Eight back-to-back reads; each response must arrive one cycle after its read.
        @(negedge clock);
        pops_before = n_pops;
        @(posedge clock);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            rd(2'd0, RV);
            rd(2'd1, 32'hDEAD_BEEF);
            rd(2'd2, 32'hA522_0044);
            rd(2'd3, 32'h0);
        end
        @(negedge clock);
        #1;
        check("stream_pulses", n_pops - pops_before, 8);
        check("stream_error", error, 1'b1);

        // Reset asserted with a read response outstanding.
        wr(2'd0, 4'hF, 32'h0102_0304);
        read    = 1'b1;
        address = 2'd2;
        @(posedge clock);
        #1;
        read = 1'b0;
        check("inflight_rdv", readdatavalid, 1'b1);
        reset = 1'b0;
        #1;
        check("async_rst_rdv", readdatavalid, 1'b0);
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_q", q, {3{RV}});
        check("async_rst_pending", pending, 1'b0);
        check("async_rst_error", error, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("post_rst_rdv", readdatavalid, 1'b0);
        check("post_rst_q", q, {3{RV}});
        rd(2'd0, RV);
        rd(2'd2, RV);

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
